// File: rtl/cic3_row_readout.sv
// Serialises one captured set of CIC filter outputs per sample strobe as a framed bit stream:
// sync header, 4-bit sequence number, then every enabled channel MSB first.
module cic3_row_readout #(
   parameter int         NUM_FILTERS = 24,
   parameter int         OUT_WIDTH   = 25,
   parameter logic [7:0] SYNC_WORD   = 8'hA5
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_FILTERS*OUT_WIDTH-1:0] din,
   input  logic                           sample_stb,
   input  logic [NUM_FILTERS-1:0]         ch_en,
   input  logic                           clr_overrun,
   output logic                           sdata,
   output logic                           sframe,
   output logic                           sfirst,
   output logic                           busy,
   output logic                           overrun
);

   localparam int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
   localparam int CNT_W = (OUT_WIDTH > 8) ? $clog2(OUT_WIDTH) : 3;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] HEADER = 2'd1;
   localparam logic [1:0] SEQ    = 2'd2;
   localparam logic [1:0] SHIFT  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(7);
   localparam logic [CNT_W-1:0] CNT_SEQ  = CNT_W'(3);
   localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(OUT_WIDTH - 1);

   logic [1:0]             state;
   logic [CNT_W-1:0]       bit_cnt;      // counts down to 0 within each field, doubling as the bit index
   logic [IDX_W-1:0]       ch_idx;
   logic [3:0]             seq_num;
   logic [OUT_WIDTH-1:0]   sh_word [NUM_FILTERS];
   logic [NUM_FILTERS-1:0] sh_en;

   logic [IDX_W-1:0] first_idx, next_idx;
   logic             next_found, last_bit, accept, drop;

   // Lowest enabled channel overall, and lowest enabled channel above the current one.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      first_idx  = '0;
      next_idx   = '0;
      next_found = 1'b0;
      for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
         if (sh_en[k]) first_idx = IDX_W'(k);
         if (sh_en[k] && (IDX_W'(k) > ch_idx)) begin
            next_found = 1'b1;
            next_idx   = IDX_W'(k);
         end
      end
   end

   assign last_bit = (bit_cnt == '0) &&
                     (((state == SEQ) && (sh_en == '0)) || ((state == SHIFT) && !next_found));
   assign accept   = sample_stb && ((state == IDLE) || last_bit);
   assign drop     = sample_stb && !accept;

   // Shadow copy of the sample set; the frame in flight reads only these.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: shadow storage is reset too, so a frame can never expose stale pre-reset data.
      if (!reset_n) begin
         sh_en <= '0;
         for (int k = 0; k < NUM_FILTERS; k++) sh_word[k] <= '0;
      end else if (accept) begin
         sh_en <= ch_en;
         for (int k = 0; k < NUM_FILTERS; k++) sh_word[k] <= din[k*OUT_WIDTH +: OUT_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
      if (!reset_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         ch_idx  <= '0;
         seq_num <= '0;
         overrun <= 1'b0;
      end else begin
         if (last_bit) seq_num <= seq_num + 1'b1;

         // A dropped strobe wins over a simultaneous clear.
         if (drop)             overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (sample_stb) begin
                  state   <= HEADER;
                  bit_cnt <= CNT_HDR;
               end
            end
            HEADER: begin
               if (bit_cnt == '0) begin
                  state   <= SEQ;
                  bit_cnt <= CNT_SEQ;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            SEQ: begin
               if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - 1'b1;
               end else if (sh_en == '0) begin
                  state   <= sample_stb ? HEADER : IDLE;
                  bit_cnt <= CNT_HDR;
               end else begin
                  state   <= SHIFT;
                  ch_idx  <= first_idx;
                  bit_cnt <= CNT_WORD;
               end
            end
            default: begin
               if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - 1'b1;
               end else if (next_found) begin
                  ch_idx  <= next_idx;
                  bit_cnt <= CNT_WORD;
               end else begin
                  state   <= sample_stb ? HEADER : IDLE;
                  bit_cnt <= CNT_HDR;
               end
            end
         endcase
      end
   end

   // Outputs decode directly from state, so reset clears them without waiting for a clock.
   always_comb begin
      sdata = 1'b0;
      case (state)
         HEADER:  sdata = SYNC_WORD[bit_cnt[2:0]];
         SEQ:     sdata = seq_num[bit_cnt[1:0]];
         SHIFT:   sdata = sh_word[ch_idx][bit_cnt];
         default: sdata = 1'b0;
      endcase
   end

   assign sframe = (state != IDLE);
   assign busy   = (state != IDLE);
   assign sfirst = (state == HEADER) && (bit_cnt == CNT_HDR);

endmodule

// File: doc/cic3_row_readout.md
CIC3_ROW_READOUT -- requirements
Module: cic3_row_readout

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 24, number of filter channels captured.
REQ-002 SHALL have parameter OUT_WIDTH, default 25, bits per filter output word.
REQ-003 SHALL have parameter SYNC_WORD, default 8'hA5, frame header pattern.
REQ-004 SHALL have port clk  input  1  common high-speed filter clock; one clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port din  input  NUM_FILTERS*OUT_WIDTH  flattened filter outputs; channel k at [OUT_WIDTH*(k+1)-1 : OUT_WIDTH*k].
REQ-007 SHALL have port sample_stb  input  1  one-clk pulse: din holds a new decimated sample set.
REQ-008 SHALL have port ch_en  input  NUM_FILTERS  per-channel enable; bit k enables channel k.
REQ-009 SHALL have port clr_overrun  input  1  synchronous clear of the overrun flag.
REQ-010 SHALL have port sdata  output  1  serial data, MSB first.
REQ-011 SHALL have port sframe  output  1  high on every cycle that carries a frame bit.
REQ-012 SHALL have port sfirst  output  1  high only on the first header bit of a frame.
REQ-013 SHALL have port busy  output  1  high while the FSM is not IDLE.
REQ-014 SHALL have port overrun  output  1  sticky flag: a sample_stb was dropped.

Function
REQ-015 SHALL implement FSM states IDLE, HEADER, SEQ, SHIFT.
REQ-016 In IDLE, sample_stb=1 SHALL capture din and ch_en into shadow registers on that edge and move to HEADER.
REQ-017 The first header bit SHALL appear on sdata in the cycle after the accepting edge, i.e. latency 1 clk, with sfirst=1 and sframe=1.
REQ-018 HEADER SHALL emit SYNC_WORD over 8 cycles, MSB first, then go to SEQ.
REQ-019 SEQ SHALL emit a 4-bit frame sequence number over 4 cycles, MSB first, then go to SHIFT, or to IDLE if the captured ch_en is all zero.
REQ-020 SHIFT SHALL emit the captured enabled channels in ascending index order, OUT_WIDTH bits each, MSB first, and skip disabled channels with no gap cycles.
REQ-021 Frame length SHALL be 12 + OUT_WIDTH*popcount(captured ch_en) cycles, with sframe continuous across the whole frame.
REQ-022 The sequence number SHALL increment by 1 at the end of each completed frame and wrap 15 to 0.
REQ-023 Outside a frame, sdata, sframe and sfirst SHALL be 0.
REQ-024 Changes to din or ch_en after capture SHALL NOT affect the frame in progress.
REQ-025 sample_stb asserted during the final bit cycle of a frame SHALL be accepted, and the next header SHALL start in the immediately following cycle with no idle gap.
REQ-026 sample_stb asserted on any other non-IDLE cycle SHALL be dropped and SHALL set overrun, which holds until clr_overrun.
REQ-027 When clr_overrun and a dropping sample_stb occur in the same cycle, the set SHALL take priority.
REQ-028 busy SHALL be 1 from the cycle after acceptance through the final bit cycle.

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE and set sdata, sframe, sfirst, busy, overrun, the sequence number and all shadow registers to 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame, and no partial bits SHALL be emitted after release.
REQ-031 After reset release, the first sample_stb SHALL be accepted normally.

Verification
REQ-032 Set all channels enabled, din channel k = k+1, send one stb -> 612-bit frame: A5, seq 0000, then 25'd1..25'd24 MSB first, sfirst on bit 0 only.
REQ-033 Set ch_en=24'h000005 -> frame carries channel 0 then channel 2, length 62; ch_en=0 -> 12-bit frame, seq still increments.
REQ-034 Send 17 frames back-to-back using last-cycle stb -> no gaps, sframe continuously high, seq 0..15 then 0, overrun stays 0.
REQ-035 Send stb at frame bit 100 -> frame unchanged, overrun=1; then clr_overrun -> overrun=0 next cycle; set/clear in the same cycle -> overrun=1.
REQ-036 Assert reset_n low at bit 300 of a frame -> outputs 0 asynchronously, seq reset; next stb yields seq 0000.
REQ-037 Change din and ch_en every cycle during a frame -> the serialized data matches the values captured at acceptance.
